// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: echo/delay controller driving a dual-port sample RAM (write port 1, read port 2).
// Optional power-up RAM clear sweep is enabled by defining DELAY_CLEAR_EN.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FB_SHIFT   = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [ADDR_WIDTH-1:0] DELAY,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] ADDR1,
    output logic [DATA_WIDTH-1:0] DI,
    output logic [ADDR_WIDTH-1:0] ADDR2,
    input  logic [DATA_WIDTH-1:0] DO2
);
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        MIX,
        WR,
        OUT
`ifdef DELAY_CLEAR_EN
        , CLEAR
`endif
    } state_t;

`ifdef DELAY_CLEAR_EN
    localparam state_t RST_ST = CLEAR;
    logic [ADDR_WIDTH:0] clr_q, clr_d;
`else
    localparam state_t RST_ST = IDLE;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] in_q, in_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;

    logic signed [DATA_WIDTH-1:0] wet;
    logic        [DATA_WIDTH:0]   sum;
    logic        [DATA_WIDTH-1:0] mix;

    // One guard bit catches signed overflow; clamp towards the overflow direction.
    assign wet = $signed(DO2) >>> FB_SHIFT;
    assign sum = {in_q[DATA_WIDTH-1], in_q} + {wet[DATA_WIDTH-1], wet};
    assign mix = (sum[DATA_WIDTH] == sum[DATA_WIDTH-1]) ? sum[DATA_WIDTH-1:0]
                                                       : {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RST_ST;
            wr_ptr_q    <= '0;
            in_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            we_q        <= 1'b0;
            addr1_q     <= '0;
            di_q        <= '0;
            addr2_q     <= '0;
`ifdef DELAY_CLEAR_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            in_q        <= in_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            we_q        <= we_d;
            addr1_q     <= addr1_d;
            di_q        <= di_d;
            addr2_q     <= addr2_d;
`ifdef DELAY_CLEAR_EN
            clr_q       <= clr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        in_d        = in_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        we_d        = we_q;
        addr1_d     = addr1_q;
        di_d        = di_q;
        addr2_d     = addr2_q;
`ifdef DELAY_CLEAR_EN
        clr_d       = clr_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (IN_VALID && in_ready_q) begin
                    in_d       = IN_DATA;
                    addr2_d    = wr_ptr_q - DELAY;
                    in_ready_d = 1'b0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: state_d = MIX;
            MIX: begin
                di_d       = mix;
                out_data_d = mix;
                addr1_d    = wr_ptr_q;
                we_d       = 1'b1;
                state_d    = WR;
            end
            WR: begin
                we_d        = 1'b0;
                wr_ptr_d    = (wr_ptr_q == ADDR_WIDTH'(SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef DELAY_CLEAR_EN
            CLEAR: begin
                if (clr_q == (ADDR_WIDTH + 1)'(SIZE)) begin
                    we_d       = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    we_d    = 1'b1;
                    di_d    = '0;
                    addr1_d = clr_q[ADDR_WIDTH-1:0];
                    clr_d   = clr_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign WE        = we_q;
    assign ADDR1     = addr1_q;
    assign DI        = di_q;
    assign ADDR2     = addr2_q;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: scoreboard bench for delay_line_ctrl with a behavioural sync-read RAM.
// Build with DELAY_CLEAR_EN defined to exercise the power-up clear sweep.
module tb_delay_line_ctrl;
    localparam int DW = 32;
    localparam int SIZE = 8;
    localparam int AW = 3;
    localparam int FB = 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA = '0;
    logic [AW-1:0] DELAY = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [DW-1:0] OUT_DATA;
    logic          WE;
    logic [AW-1:0] ADDR1;
    logic [DW-1:0] DI;
    logic [AW-1:0] ADDR2;
    logic [DW-1:0] DO2;

    logic [DW-1:0] mem [SIZE];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_a = '0;
    logic [DW-1:0] bd_d = '0;

    logic [DW-1:0] model_mem [SIZE];
    logic [AW-1:0] model_ptr;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    logic [DW-1:0] oq [$];
    int n_cmp = 0;
    int n_err = 0;

    delay_line_ctrl #(.DATA_WIDTH(DW), .SIZE(SIZE), .ADDR_WIDTH(AW), .FB_SHIFT(FB)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .DELAY(DELAY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .WE(WE), .ADDR1(ADDR1), .DI(DI), .ADDR2(ADDR2), .DO2(DO2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bd_en) mem[bd_a] <= bd_d;
        else if (WE) mem[ADDR1] <= DI;
        DO2 <= mem[ADDR2];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mix_f(input logic [DW-1:0] x, input logic [DW-1:0] stored);
        longint s;
        s = longint'($signed(x)) + (longint'($signed(stored)) >>> FB);
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
        return s[31:0];
    endfunction

    always @(negedge CLK) begin
        if (RST_N) begin
            if (WE) begin
                if (wa_q.size() == 0) chk("we_unexpected", 1, 0);
                else begin
                    chk("addr1", ADDR1, wa_q.pop_front());
                    chk("di", DI, wd_q.pop_front());
                end
            end
            if (OUT_VALID && OUT_READY) begin
                if (oq.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_data", OUT_DATA, oq.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!IN_READY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!IN_READY) chk("ready_timeout", 0, 1);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        bd_en = 1'b1; bd_a = a; bd_d = d;
        @(posedge CLK); #1;
        bd_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic zero_ram();
        for (int i = 0; i < SIZE; i++) poke(AW'(i), '0);
    endtask

    task automatic do_reset();
        int n = 0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_we", WE, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_di", DI, 0);
        chk("rst_addr1", ADDR1, 0);
        chk("rst_addr2", ADDR2, 0);
        model_ptr = '0;
`ifdef DELAY_CLEAR_EN
        for (int i = 0; i < SIZE; i++) begin
            wa_q.push_back(AW'(i));
            wd_q.push_back('0);
            model_mem[i] = '0;
        end
`endif
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        while (!IN_READY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
`ifdef DELAY_CLEAR_EN
        chk("ready_after_rst", n, SIZE + 1);
`else
        chk("ready_after_rst", n, 1);
`endif
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] dl, input int hold,
                        output logic [DW-1:0] got);
        logic [AW-1:0] a2;
        logic [DW-1:0] m;
        int lat = 0;
        wait_ready();
        a2 = model_ptr - dl;
        m = mix_f(d, model_mem[a2]);
        model_mem[model_ptr] = m;
        wa_q.push_back(model_ptr);
        wd_q.push_back(m);
        oq.push_back(m);
        model_ptr = model_ptr + 1'b1;
        OUT_READY = (hold == 0);
        IN_VALID = 1'b1; IN_DATA = d; DELAY = dl;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        IN_DATA = $urandom;
        DELAY = AW'($urandom);
        chk("addr2", ADDR2, a2);
        chk("in_ready_busy", IN_READY, 0);
        while (!OUT_VALID && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("latency", lat, 3);
        got = OUT_DATA;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk("bp_valid", OUT_VALID, 1);
            chk("bp_data", OUT_DATA, got);
            chk("bp_in_ready", IN_READY, 0);
            chk("bp_we", WE, 0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_out", IN_READY, 1);
        chk("valid_after_out", OUT_VALID, 0);
    endtask

    logic [DW-1:0] got;
    logic [DW-1:0] imp_exp [7] = '{32'd64, 32'd0, 32'd32, 32'd0, 32'd16, 32'd0, 32'd8};

    initial begin
        #3;
        do_reset();
        zero_ram();
        send(32'd100, 3'd2, 0, got);
        chk("t1_out", got, 100);

        do_reset();
        zero_ram();
        for (int i = 0; i < 7; i++) begin
            send(i == 0 ? 32'd64 : 32'd0, 3'd2, 0, got);
            chk("impulse", got, imp_exp[i]);
        end

        do_reset();
        zero_ram();
        poke(3'd7, 32'h00000040);
        send(32'h7FFFFFF0, 3'd1, 0, got);
        chk("sat_pos", got, 32'h7FFFFFFF);
        poke(3'd0, 32'hFFFFFFFE);
        send(32'h80000000, 3'd1, 0, got);
        chk("sat_neg", got, 32'h80000000);

        send(32'd5, 3'd1, 4, got);

        do_reset();
        zero_ram();
        for (int i = 1; i <= 10; i++) begin
            send(DW'(i), 3'd0, 0, got);
            chk("wrap_out", got, i == 9 ? 32'd9 : i == 10 ? 32'd11 : DW'(i));
        end

        wait_ready();
        IN_VALID = 1'b1; IN_DATA = 32'd77; DELAY = 3'd1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        do_reset();
        send(32'd9, 3'd1, 0, got);
        chk("post_rst_out", got, mix_f(32'd9, model_mem[7]));

        repeat (3) @(posedge CLK);
        #1;
        chk("out_queue_left", oq.size(), 0);
        chk("wr_queue_left", wa_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
